// File: rtl/lane_unpacker_pkg.sv
// Shared types and default geometry for the lane unpacker.
package lane_unpacker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int DEF_LANE_W    = 4;
    localparam int DEF_NUM_LANES = 2;

endpackage : lane_unpacker_pkg

// File: rtl/lane_unpacker_lane_shifter.sv
// Combinational right shift of one lane, logical (zero fill) or arithmetic (sign fill).
module lane_shifter #(
    parameter  int LANE_W = 4,
    localparam int SH_W   = $clog2(LANE_W)
) (
    input  logic [LANE_W-1:0] lane,
    input  logic [SH_W-1:0]   shamt,
    input  logic              arith,
    output logic [LANE_W-1:0] shifted
);

    // select the fill behaviour for the shift
    always_comb begin
        if (arith) begin
            shifted = $signed(lane) >>> shamt;
        end else begin
            shifted = lane >> shamt;
        end
    end

endmodule : lane_shifter

// File: rtl/lane_unpacker.sv
// Lane unpacker: takes one packed word and emits its lanes one per beat, lane 0 first,
// each lane right-shifted by the amount captured with the word.
// Optional build macro LANE_UNPACKER_B2B_EN: accept the next word on the last-lane
// handshake so consecutive words stream with no idle bubble.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word held; in_ready=1, waiting for a packed word
//   BUSY  | word held; presenting lane idx_q on the output handshake
module lane_unpacker
    import lane_unpacker_pkg::*;
#(
    parameter  int LANE_W    = DEF_LANE_W,
    parameter  int NUM_LANES = DEF_NUM_LANES,
    localparam int W         = LANE_W * NUM_LANES,
    localparam int SH_W      = $clog2(LANE_W),
    localparam int IDX_W     = $clog2(NUM_LANES) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic [SH_W-1:0]   in_shamt,
    input  logic              in_arith,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      word_q,  word_d;
    logic [SH_W-1:0]   shamt_q, shamt_d;
    logic              arith_q, arith_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [LANE_W-1:0] lane_shifted;
    logic              last_beat;

    assign last_beat = (state_q == BUSY) && (idx_q == LAST_IDX);

    // the current lane always sits in the low bits of the word register
    lane_shifter #(.LANE_W(LANE_W)) u_shifter (
        .lane    (word_q[LANE_W-1:0]),
        .shamt   (shamt_q),
        .arith   (arith_q),
        .shifted (lane_shifted)
    );

    // outputs derive from registered state only
    always_comb begin
        out_data = (state_q == BUSY) ? lane_shifted : '0;
        out_idx  = idx_q;
        out_last = last_beat;
    end

    // next-state, capture and handshake logic
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        shamt_d   = shamt_q;
        arith_d   = arith_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    shamt_d = in_shamt;
                    arith_d = in_arith;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    word_d = word_q >> LANE_W;
                    idx_d  = idx_q + 1'b1;
                    if (last_beat) begin
                        idx_d   = '0;
                        state_d = IDLE;
`ifdef LANE_UNPACKER_B2B_EN
                        // next word replaces the finished one on the same edge
                        in_ready = 1'b1;
                        if (in_valid) begin
                            word_d  = in_data;
                            shamt_d = in_shamt;
                            arith_d = in_arith;
                            state_d = BUSY;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            shamt_q <= '0;
            arith_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            shamt_q <= shamt_d;
            arith_q <= arith_d;
            idx_q   <= idx_d;
        end
    end

endmodule : lane_unpacker
